pit_wb_regs: RTL

- Wishbone revB.2 slave register front end for the PIT.
- Sits directly downstream of the wishbone_if slave modport and consumes its address, data, write-enable, cycle and select signals.
- Performs register decode, byte-lane writes, programmable wait-state acknowledge and coherent 32-bit counter reads.
- Drives the control and modulus fields into the PIT counter core.

---
 rtl/pit_regs_pkg.sv | 24 ++
 rtl/pit_wb_ack_gen.sv | 61 ++++++
 rtl/pit_wb_regs.sv | 119 +++++++++++
 3 files changed

// File: rtl/pit_regs_pkg.sv
// Shared register map, CTRL field positions and handshake state type for the PIT Wishbone front end.
package pit_regs_pkg;

   localparam logic [2:0] ADR_CTRL   = 3'd0;
   localparam logic [2:0] ADR_STAT   = 3'd1;
   localparam logic [2:0] ADR_MOD_LO = 3'd2;
   localparam logic [2:0] ADR_MOD_HI = 3'd3;
   localparam logic [2:0] ADR_CNT_LO = 3'd4;
   localparam logic [2:0] ADR_CNT_HI = 3'd5;

   localparam int CTRL_CNT_EN  = 0;
   localparam int CTRL_IRQ_EN  = 1;
   localparam int CTRL_CNT_CLR = 2;
   localparam int CTRL_PRE_LSB = 8;
   localparam int CTRL_PRE_MSB = 15;
   localparam int STAT_FLAG    = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } ack_state_t;

endpackage

// File: rtl/pit_wb_ack_gen.sv
// Wishbone handshake: ack rises WAIT_STATES+1 cycles after request, lasts one cycle;
// dropping the request while waiting aborts; commit marks the edge entering ACK.
module pit_wb_ack_gen
   import pit_regs_pkg::*;
#(
   parameter int WAIT_STATES = 1
) (
   input  logic wb_clk,
   input  logic wb_rst,
   input  logic request,
   output logic ack,
   output logic commit
);

   localparam logic [1:0] WAIT_LOAD = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

   ack_state_t state, state_nxt;
   logic [1:0] wait_cnt, wait_cnt_nxt;

   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         state    <= IDLE;
         wait_cnt <= 2'd0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      case (state)
         IDLE: begin
            if (request) begin
               if (WAIT_STATES == 0) begin
                  state_nxt = ACK;
               end else begin
                  state_nxt    = WAIT;
                  wait_cnt_nxt = WAIT_LOAD;
               end
            end
         end
         WAIT: begin
            if (!request)
               state_nxt = IDLE;
            else if (wait_cnt == 2'd0)
               state_nxt = ACK;
            else
               wait_cnt_nxt = wait_cnt - 2'd1;
         end
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign ack    = (state == ACK);
   // Suppressed under reset so no write or snapshot lands on a reset edge.
   assign commit = (state_nxt == ACK) && !wb_rst;

endmodule

// File: rtl/pit_wb_regs.sv
// PIT Wishbone register bank: byte-lane writes and read-data load on the edge entering ACK,
// coherent 32-bit counter read via CNT_LO-captured high-half shadow.
module pit_wb_regs
   import pit_regs_pkg::*;
#(
   parameter int D_WIDTH     = 16,
   parameter int A_WIDTH     = 3,
   parameter int S_WIDTH     = 2,
   parameter int WAIT_STATES = 1,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                 wb_clk,
   input  logic                 wb_rst,
   input  logic [A_WIDTH-1:0]   wb_adr_i,
   input  logic [D_WIDTH-1:0]   wb_dat_i,
   input  logic                 wb_we_i,
   input  logic                 wb_cyc_i,
   input  logic                 wb_stb_i,
   input  logic [S_WIDTH-1:0]   wb_sel_i,
   output logic [D_WIDTH-1:0]   wb_dat_o,
   output logic                 wb_ack_o,
   input  logic [CNT_WIDTH-1:0] cnt_value,
   input  logic                 cnt_flag_set,
   output logic                 cnt_en,
   output logic                 irq_en,
   output logic                 cnt_clr,
   output logic [7:0]           prescale,
   output logic [CNT_WIDTH-1:0] modulus,
   output logic                 irq_o
);

   logic               request, commit, wr_commit, rd_commit;
   logic               cnt_flag;
   logic [D_WIDTH-1:0] cnt_hi_shadow;
   logic [D_WIDTH-1:0] rd_mux;

   assign request   = wb_cyc_i & wb_stb_i;
   assign wr_commit = commit & wb_we_i;
   assign rd_commit = commit & ~wb_we_i;

   pit_wb_ack_gen #(
      .WAIT_STATES(WAIT_STATES)
   ) u_ack_gen (
      .wb_clk  (wb_clk),
      .wb_rst  (wb_rst),
      .request (request),
      .ack     (wb_ack_o),
      .commit  (commit)
   );

   always_comb begin
      rd_mux = '0;
      case (wb_adr_i)
         ADR_CTRL: begin
            rd_mux[CTRL_CNT_EN]                = cnt_en;
            rd_mux[CTRL_IRQ_EN]                = irq_en;
            rd_mux[CTRL_PRE_MSB:CTRL_PRE_LSB]  = prescale;
         end
         ADR_STAT:   rd_mux[STAT_FLAG] = cnt_flag;
         ADR_MOD_LO: rd_mux = modulus[D_WIDTH-1:0];
         ADR_MOD_HI: rd_mux = modulus[CNT_WIDTH-1:D_WIDTH];
         ADR_CNT_LO: rd_mux = cnt_value[D_WIDTH-1:0];
         ADR_CNT_HI: rd_mux = cnt_hi_shadow;
         default:    rd_mux = '0;
      endcase
   end

   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         cnt_en        <= 1'b0;
         irq_en        <= 1'b0;
         cnt_clr       <= 1'b0;
         prescale      <= 8'd0;
         modulus       <= '0;
         cnt_flag      <= 1'b0;
         cnt_hi_shadow <= '0;
         wb_dat_o      <= '0;
      end else begin
         cnt_clr <= 1'b0;
         // A rollover on the same edge as a clear must not be lost.
         if (cnt_flag_set)
            cnt_flag <= 1'b1;
         else if (wr_commit && wb_adr_i == ADR_STAT && wb_sel_i[0] && wb_dat_i[STAT_FLAG])
            cnt_flag <= 1'b0;

         if (wr_commit) begin
            case (wb_adr_i)
               ADR_CTRL: begin
                  if (wb_sel_i[0]) begin
                     cnt_en  <= wb_dat_i[CTRL_CNT_EN];
                     irq_en  <= wb_dat_i[CTRL_IRQ_EN];
                     cnt_clr <= wb_dat_i[CTRL_CNT_CLR];
                  end
                  if (wb_sel_i[1])
                     prescale <= wb_dat_i[CTRL_PRE_MSB:CTRL_PRE_LSB];
               end
               ADR_MOD_LO: begin
                  if (wb_sel_i[0]) modulus[7:0]  <= wb_dat_i[7:0];
                  if (wb_sel_i[1]) modulus[15:8] <= wb_dat_i[15:8];
               end
               ADR_MOD_HI: begin
                  if (wb_sel_i[0]) modulus[23:16] <= wb_dat_i[7:0];
                  if (wb_sel_i[1]) modulus[31:24] <= wb_dat_i[15:8];
               end
               default: ;
            endcase
         end

         if (rd_commit) begin
            wb_dat_o <= rd_mux;
            if (wb_adr_i == ADR_CNT_LO)
               cnt_hi_shadow <= cnt_value[CNT_WIDTH-1:D_WIDTH];
         end
      end
   end

   assign irq_o = cnt_flag & irq_en;

endmodule
